// File: rtl/intt_butterfly_pipe.sv
// rtl/intt_butterfly_pipe.sv - Gentleman-Sande inverse butterfly, 3-stage valid/ready pipeline
module intt_butterfly_pipe #(
    parameter int MODULUS = 7681,
    parameter int HALVE   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] buffer_data_in,
    input  logic [31:0] normal_data_in,
    input  logic [31:0] twiddle_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] positive_data_out,
    output logic [31:0] negative_data_out,
    output logic        range_err
);

    localparam logic [31:0] Q32 = 32'(MODULUS);
    localparam logic [32:0] Q33 = 33'(MODULUS);
    localparam logic [63:0] Q64 = 64'(MODULUS);

    // x * 2^-1 mod Q: odd values get Q added first so the shift is exact
    function automatic logic [31:0] halve_mod(input logic [31:0] x);
        logic [32:0] t;
        t = x[0] ? ({1'b0, x} + Q33) : {1'b0, x};
        return t[32:1];
    endfunction

    logic        stall;
    logic        en;
    logic        in_fire;

    logic        v1_q, v1_d;
    logic [31:0] s1_q, s1_d;
    logic [31:0] d1_q, d1_d;
    logic [31:0] w1_q, w1_d;

    logic        v2_q, v2_d;
    logic [63:0] p2_q, p2_d;
    logic [31:0] s2_q, s2_d;

    logic        v3_q, v3_d;
    logic [31:0] pos_q, pos_d;
    logic [31:0] neg_q, neg_d;

    logic        range_err_q, range_err_d;

    // Global enable: the whole pipe freezes while the output is held off
    always_comb begin
        stall   = v3_q & ~out_ready;
        en      = ~stall;
        in_fire = in_valid & en;
    end

    // Stage 1: modular sum and non-wrapping difference
    always_comb begin
        logic [32:0] sum;
        logic [32:0] diff;
        v1_d = v1_q;
        s1_d = s1_q;
        d1_d = d1_q;
        w1_d = w1_q;
        sum  = {1'b0, buffer_data_in} + {1'b0, normal_data_in};
        if (buffer_data_in >= normal_data_in) begin
            diff = {1'b0, buffer_data_in} - {1'b0, normal_data_in};
        end else begin
            diff = {1'b0, buffer_data_in} - {1'b0, normal_data_in} + Q33;
        end
        if (en) begin
            v1_d = in_valid;
            s1_d = (sum >= Q33) ? 32'(sum - Q33) : sum[31:0];
            d1_d = diff[31:0];
            w1_d = twiddle_in;
        end
    end

    // Stage 2: full-width difference * twiddle product
    always_comb begin
        v2_d = v2_q;
        p2_d = p2_q;
        s2_d = s2_q;
        if (en) begin
            v2_d = v1_q;
            p2_d = {32'd0, d1_q} * {32'd0, w1_q};
            s2_d = s1_q;
        end
    end

    // Stage 3: exact reduction, optional halving; data only updates on a real result
    always_comb begin
        logic [63:0] red;
        logic [31:0] v_mod;
        v3_d  = v3_q;
        pos_d = pos_q;
        neg_d = neg_q;
        red   = p2_q % Q64;
        v_mod = red[31:0];
        if (en) begin
            v3_d = v2_q;
            if (v2_q) begin
                pos_d = (HALVE != 0) ? halve_mod(s2_q) : s2_q;
                neg_d = (HALVE != 0) ? halve_mod(v_mod) : v_mod;
            end
        end
    end

    // Sticky flag for any accepted operand outside 0..Q-1
    always_comb begin
        range_err_d = range_err_q;
        if (in_fire && ((buffer_data_in >= Q32) || (normal_data_in >= Q32) || (twiddle_in >= Q32))) begin
            range_err_d = 1'b1;
        end
    end

    // Pipeline and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q        <= 1'b0;
            s1_q        <= '0;
            d1_q        <= '0;
            w1_q        <= '0;
            v2_q        <= 1'b0;
            p2_q        <= '0;
            s2_q        <= '0;
            v3_q        <= 1'b0;
            pos_q       <= '0;
            neg_q       <= '0;
            range_err_q <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            s1_q        <= s1_d;
            d1_q        <= d1_d;
            w1_q        <= w1_d;
            v2_q        <= v2_d;
            p2_q        <= p2_d;
            s2_q        <= s2_d;
            v3_q        <= v3_d;
            pos_q       <= pos_d;
            neg_q       <= neg_d;
            range_err_q <= range_err_d;
        end
    end

    assign in_ready          = en;
    assign out_valid         = v3_q;
    assign positive_data_out = pos_q;
    assign negative_data_out = neg_q;
    assign range_err         = range_err_q;

endmodule

// File: tb/tb_intt_butterfly_pipe.sv
// tb/tb_intt_butterfly_pipe.sv - self-checking bench for intt_butterfly_pipe (HALVE=0 and HALVE=1)
module tb_intt_butterfly_pipe;

    localparam int Q = 7681;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] a_in = '0, b_in = '0, w_in = '0;

    logic        in_ready0, out_valid0, range_err0;
    logic [31:0] pos0, neg0;
    logic        in_ready1, out_valid1, range_err1;
    logic [31:0] pos1, neg1;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] u;
        logic [31:0] v;
        bit          chk;
    } exp_t;

    typedef struct {
        logic [31:0] a, b, w;
        logic [31:0] u0, v0, u1, v1;
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    intt_butterfly_pipe #(.MODULUS(Q), .HALVE(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .buffer_data_in(a_in), .normal_data_in(b_in), .twiddle_in(w_in),
        .out_valid(out_valid0), .out_ready(out_ready),
        .positive_data_out(pos0), .negative_data_out(neg0), .range_err(range_err0)
    );

    intt_butterfly_pipe #(.MODULUS(Q), .HALVE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .buffer_data_in(a_in), .normal_data_in(b_in), .twiddle_in(w_in),
        .out_valid(out_valid1), .out_ready(out_ready),
        .positive_data_out(pos1), .negative_data_out(neg1), .range_err(range_err1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] half_q(input longint x);
        return (x % 2 == 1) ? 32'((x + Q) / 2) : 32'(x / 2);
    endfunction

    // Drive one pair, wait (bounded) until accepted, push expectations at acceptance
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] w,
                        input logic [31:0] u0, input logic [31:0] v0,
                        input logic [31:0] u1, input logic [31:0] v1, input bit chk);
        bit ok;
        ok = 0;
        in_valid = 1'b1;
        a_in = a; b_in = b; w_in = w;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready0) begin ok = 1; break; end
        end
        n_assert++;
        if (!ok) begin
            n_fail++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1");
        end else begin
            q0.push_back('{u: u0, v: v0, chk: chk});
            q1.push_back('{u: u1, v: v1, chk: chk});
        end
        @(posedge clk); #1;
    endtask

    task automatic send_model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] w);
        longint u, v;
        u = (longint'(a) + longint'(b)) % Q;
        v = (((longint'(a) + Q - longint'(b)) % Q) * longint'(w)) % Q;
        send(a, b, w, 32'(u), 32'(v), half_q(u), half_q(v), 1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0) break;
        end
        check("drain_q0_empty", 32'(q0.size()), 32'd0);
        check("drain_q1_empty", 32'(q1.size()), 32'd0);
    endtask

    // Scoreboard: pop on output transfer, and track in_ready = ~stall
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("in_ready0", {31'd0, in_ready0}, {31'd0, !(out_valid0 && !out_ready)});
            check("in_ready1", {31'd0, in_ready1}, {31'd0, !(out_valid1 && !out_ready)});
            if (out_valid0 && out_ready) begin
                if (q0.size() == 0) begin
                    n_assert++; n_fail++;
                    $display("FAIL dut0_unexpected_output: got u=%0d expected none", pos0);
                end else begin
                    e = q0.pop_front();
                    if (e.chk) begin
                        check("dut0_u", pos0, e.u);
                        check("dut0_v", neg0, e.v);
                    end
                end
            end
            if (out_valid1 && out_ready) begin
                if (q1.size() == 0) begin
                    n_assert++; n_fail++;
                    $display("FAIL dut1_unexpected_output: got u=%0d expected none", pos1);
                end else begin
                    e = q1.pop_front();
                    if (e.chk) begin
                        check("dut1_u", pos1, e.u);
                        check("dut1_v", neg1, e.v);
                    end
                end
            end
        end
    end

    vec_t vecs[5];
    int   lat;
    int   low_cnt;

    initial begin
        vecs[0] = '{a: 5,    b: 3,    w: 2,    u0: 8,    v0: 4,    u1: 4,    v1: 2};
        vecs[1] = '{a: 3,    b: 5,    w: 2,    u0: 8,    v0: 7677, u1: 4,    v1: 7679};
        vecs[2] = '{a: 7680, b: 7680, w: 1,    u0: 7679, v0: 0,    u1: 7680, v1: 0};
        vecs[3] = '{a: 7680, b: 0,    w: 7680, u0: 7680, v0: 1,    u1: 3840, v1: 3841};
        vecs[4] = '{a: 0,    b: 1,    w: 1,    u0: 1,    v0: 7680, u1: 3841, v1: 3840};

        // Reset state
        #12;
        check("rst_out_valid0", {31'd0, out_valid0}, 32'd0);
        check("rst_out_valid1", {31'd0, out_valid1}, 32'd0);
        check("rst_pos0", pos0, 32'd0);
        check("rst_neg1", neg1, 32'd0);
        check("rst_range_err0", {31'd0, range_err0}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready0", {31'd0, in_ready0}, 32'd1);
        @(posedge clk); #1;

        // Latency: single pair, out_valid must appear on the third cycle after accept
        send(vecs[0].a, vecs[0].b, vecs[0].w, vecs[0].u0, vecs[0].v0, vecs[0].u1, vecs[0].v1, 1);
        idle();
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (out_valid0) begin lat = k; break; end
        end
        check("latency", 32'(lat), 32'd3);
        drain();

        // Table vectors streamed back to back
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].w, vecs[i].u0, vecs[i].v0, vecs[i].u1, vecs[i].v1, 1);
        end
        idle();
        drain();

        // Backpressure: 8 random pairs, out_ready low for 4 cycles mid-stream
        @(posedge clk); #1;
        low_cnt = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send_model($urandom_range(0, Q - 1), $urandom_range(0, Q - 1), $urandom_range(0, Q - 1));
                end
                idle();
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    if (!in_ready0) low_cnt++;
                    @(posedge clk);
                end
                #1 out_ready = 1'b1;
            end
        join
        check("bp_in_ready_low_cycles", 32'(low_cnt), 32'd4);
        drain();

        // Reset with pairs in flight, output stalled and valid
        @(posedge clk); #1;
        out_ready = 1'b0;
        send_model(11, 22, 33);
        send_model(44, 55, 66);
        send_model(77, 88, 99);
        idle();
        @(negedge clk);
        check("pre_rst_out_valid", {31'd0, out_valid0}, 32'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid0", {31'd0, out_valid0}, 32'd0);
        check("async_rst_out_valid1", {31'd0, out_valid1}, 32'd0);
        check("async_rst_pos0", pos0, 32'd0);
        check("async_rst_neg0", neg0, 32'd0);
        check("async_rst_pos1", pos1, 32'd0);
        q0.delete();
        q1.delete();
        out_ready = 1'b1;
        @(negedge clk); rst = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_out_valid", {31'd0, out_valid0}, 32'd0);

        // Range error: sticky after an out-of-range operand is accepted
        @(posedge clk); #1;
        check("range_err_before", {31'd0, range_err0}, 32'd0);
        send(32'd7681, 32'd0, 32'd1, 0, 0, 0, 0, 0);
        idle();
        check("range_err0_set", {31'd0, range_err0}, 32'd1);
        check("range_err1_set", {31'd0, range_err1}, 32'd1);
        send_model(100, 200, 300);
        idle();
        drain();
        check("range_err_sticky", {31'd0, range_err0}, 32'd1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("range_err_cleared", {31'd0, range_err0}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
